// File: rtl/adt7420_i2c_target.sv
// ADT7420 register-map emulation as an I2C target on an open-drain SDA/SCL pair.
// SCL/SDA are oversampled on clk; the target never stretches the clock.
module adt7420_i2c_target #(
    parameter logic [6:0]  I2C_ADDR = 7'h4B,
    parameter int unsigned HOLD_CYC = 4,
    parameter logic [7:0]  ID_VALUE = 8'hCB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_value,
    output logic [7:0]  config_reg,
    output logic        rd_done,
    output logic        wr_done,
    output logic        busy
);
    localparam int unsigned   HW        = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_ZERO = HW'(0);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_PTR, ST_PTR_ACK,
        ST_WR_DATA, ST_DATA_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
    } state_t;

    state_t        state_r, state_next_s;
    logic          busy_next_s;
    logic          scl_meta_r, scl_sync_r, scl_d_r;
    logic          sda_meta_r, sda_sync_r, sda_d_r;
    logic          scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [2:0]    bit_cnt_r;
    logic          last_bit_s;
    logic [7:0]    shift_r;
    logic          rw_r;
    logic [7:0]    ptr_r;
    logic [15:0]   shadow_r;
    logic [7:0]    config_r;
    logic [7:0]    rd_byte_s;
    logic          drive_s;
    logic [HW-1:0] hold_cnt_r;
    logic          sda_oe_r, rd_done_r, wr_done_r, busy_r;

    assign scl_rise_s = scl_sync_r & ~scl_d_r;
    assign scl_fall_s = ~scl_sync_r & scl_d_r;
    // START/STOP need SCL high in both samples so they can never coincide with an SCL edge
    assign start_s    = scl_sync_r & scl_d_r & sda_d_r & ~sda_sync_r;
    assign stop_s     = scl_sync_r & scl_d_r & ~sda_d_r & sda_sync_r;
    assign last_bit_s = (bit_cnt_r == 3'd7);

    assign sda_oe     = sda_oe_r;
    assign config_reg = config_r;
    assign rd_done    = rd_done_r;
    assign wr_done    = wr_done_r;
    assign busy       = busy_r;

    // Two-flop synchronisers plus one delay stage for edge detection; idle bus is high
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_d_r    <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_meta_r <= scl_in;
            scl_sync_r <= scl_meta_r;
            scl_d_r    <= scl_sync_r;
            sda_meta_r <= sda_in;
            sda_sync_r <= sda_meta_r;
            sda_d_r    <= sda_sync_r;
        end
    end

    // Register-map read mux addressed by the pointer
    always_comb begin
        rd_byte_s = 8'h00;
        case (ptr_r)
            8'h00:   rd_byte_s = shadow_r[15:8];
            8'h01:   rd_byte_s = shadow_r[7:0];
            8'h03:   rd_byte_s = config_r;
            8'h0B:   rd_byte_s = ID_VALUE;
            default: rd_byte_s = 8'h00;
        endcase
    end

    // Level SDA should take once the hold time after an SCL fall has elapsed
    always_comb begin
        drive_s = 1'b0;
        case (state_r)
            ST_ADDR_ACK, ST_PTR_ACK, ST_DATA_ACK: drive_s = 1'b1;
            ST_RD_DATA: drive_s = ~rd_byte_s[3'd7 - bit_cnt_r];
            default:    drive_s = 1'b0;
        endcase
    end

    // Next-state logic: START/STOP take priority, otherwise advance on SCL rise
    always_comb begin
        state_next_s = state_r;
        busy_next_s  = 1'b0;
        if (start_s) begin
            state_next_s = ST_ADDR;
        end else if (stop_s) begin
            state_next_s = ST_IDLE;
        end else if (scl_rise_s) begin
            case (state_r)
                ST_ADDR: begin
                    if (last_bit_s) begin
                        state_next_s = (shift_r[6:0] == I2C_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                    end else begin
                        state_next_s = ST_ADDR;
                    end
                end
                ST_ADDR_ACK: state_next_s = rw_r ? ST_RD_DATA : ST_WR_PTR;
                ST_WR_PTR:   state_next_s = last_bit_s ? ST_PTR_ACK : ST_WR_PTR;
                ST_PTR_ACK:  state_next_s = ST_WR_DATA;
                ST_WR_DATA:  state_next_s = last_bit_s ? ST_DATA_ACK : ST_WR_DATA;
                ST_DATA_ACK: state_next_s = ST_WR_DATA;
                ST_RD_DATA:  state_next_s = last_bit_s ? ST_RD_ACK : ST_RD_DATA;
                ST_RD_ACK:   state_next_s = sda_sync_r ? ST_IGNORE : ST_RD_DATA;
                default:     state_next_s = state_r;
            endcase
        end else begin
            state_next_s = state_r;
        end
        case (state_next_s)
            ST_IDLE, ST_ADDR, ST_IGNORE: busy_next_s = 1'b0;
            default:                     busy_next_s = 1'b1;
        endcase
    end

    // State register and registered busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= busy_next_s;
        end
    end

    // Bit shifting, pointer/register updates, SDA launch after the hold delay, done pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            rw_r       <= 1'b0;
            ptr_r      <= 8'h00;
            shadow_r   <= 16'h0000;
            config_r   <= 8'h00;
            hold_cnt_r <= HOLD_ZERO;
            sda_oe_r   <= 1'b0;
            rd_done_r  <= 1'b0;
            wr_done_r  <= 1'b0;
        end else begin
            rd_done_r <= 1'b0;
            wr_done_r <= 1'b0;
            if (start_s || stop_s) begin
                bit_cnt_r <= 3'd0;
            end else if (scl_rise_s) begin
                case (state_r)
                    ST_ADDR: begin
                        shift_r   <= {shift_r[6:0], sda_sync_r};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (last_bit_s) begin
                            rw_r <= sda_sync_r;
                        end
                    end
                    ST_WR_PTR: begin
                        shift_r   <= {shift_r[6:0], sda_sync_r};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (last_bit_s) begin
                            ptr_r <= {shift_r[6:0], sda_sync_r};
                        end
                    end
                    ST_WR_DATA: begin
                        shift_r   <= {shift_r[6:0], sda_sync_r};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end
                    ST_ADDR_ACK: begin
                        bit_cnt_r <= 3'd0;
                        if (rw_r) begin
                            shadow_r <= temp_value;
                        end
                    end
                    ST_RD_DATA: bit_cnt_r <= bit_cnt_r + 3'd1;
                    ST_RD_ACK: begin
                        rd_done_r <= 1'b1;
                        bit_cnt_r <= 3'd0;
                        if (!sda_sync_r) begin
                            ptr_r <= ptr_r + 8'd1;
                        end
                    end
                    default: bit_cnt_r <= bit_cnt_r;
                endcase
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end

            if (start_s || stop_s) begin
                hold_cnt_r <= HOLD_ZERO;
                sda_oe_r   <= 1'b0;
            end else if (scl_fall_s) begin
                hold_cnt_r <= HOLD_LOAD;
            end else if (hold_cnt_r == HOLD_ONE) begin
                hold_cnt_r <= HOLD_ZERO;
                sda_oe_r   <= drive_s;
                if (state_r == ST_DATA_ACK) begin
                    wr_done_r <= 1'b1;
                    ptr_r     <= ptr_r + 8'd1;
                    if (ptr_r == 8'h03) begin
                        config_r <= shift_r;
                    end
                end
            end else if (hold_cnt_r != HOLD_ZERO) begin
                hold_cnt_r <= hold_cnt_r - HOLD_ONE;
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end
endmodule
